k051962_gfx_rom_arbiter: RTL and testbench
==========================================

// Module: k051962_gfx_rom_arbiter
// PURPOSE
//  Time-slot arbiter sharing the 512Kx32 GFX tile ROM between four requesters:
//  FIX layer (id 0), layer A (id 1), layer B (id 2) and CPU ROM readback (id 3, RMRD path).
//  Drives ROM address, chip enable and half-bank selects, then returns the sampled 32-bit word
//  tagged with the requester id. Sits between the tilemap fetch logic and the ROM pairs
//  (lower half ADDR[18]=0, upper half ADDR[18]=1).
// PARAMETERS
//  SLOT_CYC    8   M24 cycles per ROM access slot (333 ns at 24 MHz); legal range 2..16
//  SAMPLE_CYC  7   slot cycle whose closing edge samples rom_data; must be <= SLOT_CYC-1
//  CPU_STARVE  4   video slots granted while cpu_req is waiting before the CPU is forced in
// PORTS
//  M24       in   1   master clock; all logic on the rising edge
//  RES       in   1   asynchronous reset, active-high
//  req       in   4   request per id, held high with its address stable until gnt
//  fix_addr  in   19  ROM word address, id 0
//  a_addr    in   19  ROM word address, id 1
//  b_addr    in   19  ROM word address, id 2
//  cpu_addr  in   19  ROM word address, id 3
//  gnt       out  4   one-hot grant; high for slot cycle 0 only
//  rom_addr  out  19  registered ROM address
//  rom_cen   out  1   ROM chip enable, active-low
//  rom_h18   out  1   = rom_addr[18]; OE of lower-half ROMs
//  rom_h18n  out  1   = ~rom_addr[18]; OE of upper-half ROMs
//  rom_data  in   32  ROM data bus
//  rd_data   out  32  sampled ROM word
//  rd_id     out  2   id owning rd_data
//  rd_vld    out  1   one-cycle pulse; rd_data and rd_id valid
//  busy      out  1   high while a slot is active
// BEHAVIOUR
//  Reset (async): gnt=0, rom_addr=0, rom_cen=1, rom_h18=0, rom_h18n=1, rd_data=0,
//   rd_id=0, rd_vld=0, busy=0, FSM=IDLE, slot_cnt=0, rr_ptr=0, cpu_wait=0.
//  FSM states: IDLE and SLOT. slot_cnt counts 0..SLOT_CYC-1 while in SLOT.
//  Decision point: any edge in IDLE, or the edge closing slot cycle SLOT_CYC-1.
//   With any req high there, the same edge sets gnt, rom_addr, rom_cen=0, busy=1 and
//   state=SLOT, slot_cnt=0. Back-to-back slots have no idle cycle.
//   With no req there, the FSM goes or stays IDLE, rom_cen=1 and rom_addr holds.
//  Selection:
//   - Force CPU if req[3] && cpu_wait>=CPU_STARVE.
//   - Otherwise pick the first video req (ids 0..2) searching upward from rr_ptr, mod 3.
//   - Otherwise pick the CPU if req[3].
//   - After a video grant, rr_ptr <= granted id + 1 (mod 3). A CPU grant leaves rr_ptr unchanged.
//  cpu_wait: +1 per video grant while req[3] is high, saturating at CPU_STARVE.
//   Cleared on a CPU grant and whenever req[3] is low.
//  Latency: req seen at a decision edge gives gnt plus address on the next cycle.
//   The edge closing slot cycle SAMPLE_CYC latches rom_data into rd_data and the granted id
//   into rd_id. rd_vld is high for the single following cycle.
//   With the defaults, rd_vld coincides with cycle 0 of the next slot.
//  Address: rom_addr is held constant for the whole slot.
//   rom_h18 and rom_h18n are decoded combinationally from the registered rom_addr[18],
//   so they are glitch-free relative to rom_addr.
//  A requester may drop req after its gnt. A req dropped before grant is ignored.
//   A req still high after gnt is a new request.
//  Reset mid-slot: the slot is abandoned, no rd_vld is issued, and outputs take reset values
//   immediately. After RES falls, arbitration restarts from rr_ptr=0.
// TESTING
//  1 Assert RES at any time -> rom_cen=1, rom_addr=0, gnt=0, rd_vld=0, rom_h18n=1, without a clock edge.
//  2 req=4'b0001, fix_addr=19'h00003 from IDLE -> gnt=0001 one cycle later;
//    rom_addr=0x00003 and rom_cen=0 for 8 cycles; rd_vld pulse with rd_id=0 and
//    rd_data equal to the ROM model word at 0x00003.
//  3 req=4'b0111 held -> grant order 0,1,2,0,1,2 on consecutive 8-cycle slots; rom_cen never
//    returns high; each rd_id matches its slot.
//  4 req=4'b1111 held, cpu_addr=19'h4001C -> 4 video slots (0,1,2,0), then a CPU slot with
//    rom_h18=1, rom_h18n=0; video order then resumes at id 1.
//  5 Single B slot, RES pulsed during slot cycle 3 -> no rd_vld. After release with req[2]
//    still high, a new grant to id 2 and a full slot follow.
//  6 req[1] pulsed for 1 cycle while a FIX slot is running, away from a decision edge ->
//    no grant to id 1; FSM returns to IDLE after the FIX slot.

Source files
------------

// File: rtl/k051962_gfx_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : k051962_gfx_rom_arbiter_if
// Brief    : Requester / ROM-side bundle for the K051962 GFX ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface k051962_gfx_rom_arbiter_if;
    logic [3:0]  req;
    logic [18:0] fix_addr;
    logic [18:0] a_addr;
    logic [18:0] b_addr;
    logic [18:0] cpu_addr;
    logic [3:0]  gnt;
    logic [18:0] rom_addr;
    logic        rom_cen;
    logic        rom_h18;
    logic        rom_h18n;
    logic [31:0] rom_data;
    logic [31:0] rd_data;
    logic [1:0]  rd_id;
    logic        rd_vld;
    logic        busy;

    // Arbiter side
    modport slave (
        input  req, fix_addr, a_addr, b_addr, cpu_addr, rom_data,
        output gnt, rom_addr, rom_cen, rom_h18, rom_h18n,
               rd_data, rd_id, rd_vld, busy
    );

    // Requester / ROM-model side
    modport master (
        output req, fix_addr, a_addr, b_addr, cpu_addr, rom_data,
        input  gnt, rom_addr, rom_cen, rom_h18, rom_h18n,
               rd_data, rd_id, rd_vld, busy
    );
endinterface
`default_nettype wire

// File: rtl/k051962_gfx_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : k051962_gfx_rom_arbiter
// Brief    : Time-slot arbiter sharing the 512Kx32 GFX tile ROM between FIX,
//            layer A, layer B and CPU readback; returns id-tagged ROM words.
// Revision : 1.0 - initial release
// ============================================================================
module k051962_gfx_rom_arbiter #(
    parameter int SLOT_CYC   = 8,
    parameter int SAMPLE_CYC = 7,
    parameter int CPU_STARVE = 4
) (
    input  wire logic                   clk,   // M24 master clock
    input  wire logic                   rst,   // asynchronous, active-high
    k051962_gfx_rom_arbiter_if.slave    bus
);

    localparam int CNT_W  = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
    localparam int WAIT_W = $clog2(CPU_STARVE + 1);

    localparam logic [CNT_W-1:0]  c_slot_last = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0]  c_sample    = CNT_W'(SAMPLE_CYC);
    localparam logic [WAIT_W-1:0] c_starve    = WAIT_W'(CPU_STARVE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_slot_cnt;
    logic [1:0]        r_rr_ptr;
    logic [WAIT_W-1:0] r_cpu_wait;
    logic [1:0]        r_slot_id;
    logic [3:0]        r_gnt;
    logic [18:0]       r_rom_addr;
    logic              r_rom_cen;
    logic [31:0]       r_rd_data;
    logic [1:0]        r_rd_id;
    logic              r_rd_vld;
    logic              r_busy;

    logic              w_decide;
    logic              w_sel_valid;
    logic              w_sel_video;
    logic [1:0]        w_sel_id;
    logic [2:0]        w_cand;
    logic [18:0]       w_sel_addr;
    logic [1:0]        w_next_ptr;

    assign w_decide = (r_state == ST_IDLE) || (r_slot_cnt == c_slot_last);

    // Starvation override first, then round-robin over video ids, then CPU.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_video = 1'b0;
        w_sel_id    = 2'd0;
        w_cand      = 3'd0;
        if (bus.req[3] && (r_cpu_wait >= c_starve)) begin
            w_sel_valid = 1'b1;
            w_sel_id    = 2'd3;
        end else begin
            for (int k = 0; k < 3; k++) begin
                w_cand = {1'b0, r_rr_ptr} + 3'(k);
                if (w_cand >= 3'd3) begin
                    w_cand = w_cand - 3'd3;
                end
                if (!w_sel_valid && bus.req[w_cand[1:0]]) begin
                    w_sel_valid = 1'b1;
                    w_sel_video = 1'b1;
                    w_sel_id    = w_cand[1:0];
                end
            end
            if (!w_sel_valid && bus.req[3]) begin
                w_sel_valid = 1'b1;
                w_sel_id    = 2'd3;
            end
        end
    end

    always_comb begin
        w_sel_addr = bus.fix_addr;
        case (w_sel_id)
            2'd0:    w_sel_addr = bus.fix_addr;
            2'd1:    w_sel_addr = bus.a_addr;
            2'd2:    w_sel_addr = bus.b_addr;
            default: w_sel_addr = bus.cpu_addr;
        endcase
    end

    assign w_next_ptr = (w_sel_id == 2'd2) ? 2'd0 : (w_sel_id + 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_slot_cnt <= '0;
            r_rr_ptr   <= 2'd0;
            r_cpu_wait <= '0;
            r_slot_id  <= 2'd0;
            r_gnt      <= 4'd0;
            r_rom_addr <= 19'd0;
            r_rom_cen  <= 1'b1;
            r_rd_data  <= 32'd0;
            r_rd_id    <= 2'd0;
            r_rd_vld   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_gnt    <= 4'd0;
            r_rd_vld <= 1'b0;

            if ((r_state == ST_SLOT) && (r_slot_cnt == c_sample)) begin
                r_rd_data <= bus.rom_data;
                r_rd_id   <= r_slot_id;
                r_rd_vld  <= 1'b1;
            end

            if (w_decide) begin
                r_slot_cnt <= '0;
                if (w_sel_valid) begin
                    r_state    <= ST_SLOT;
                    r_gnt      <= 4'b0001 << w_sel_id;
                    r_rom_addr <= w_sel_addr;
                    r_rom_cen  <= 1'b0;
                    r_busy     <= 1'b1;
                    r_slot_id  <= w_sel_id;
                    if (w_sel_video) begin
                        r_rr_ptr <= w_next_ptr;
                    end
                end else begin
                    r_state   <= ST_IDLE;
                    r_rom_cen <= 1'b1;
                    r_busy    <= 1'b0;
                end
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end

            // Starvation counter only accumulates while the CPU is actually waiting.
            if (!bus.req[3]) begin
                r_cpu_wait <= '0;
            end else if (w_decide && w_sel_valid) begin
                if (!w_sel_video) begin
                    r_cpu_wait <= '0;
                end else if (r_cpu_wait < c_starve) begin
                    r_cpu_wait <= r_cpu_wait + 1'b1;
                end
            end
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.rom_addr = r_rom_addr;
    assign bus.rom_cen  = r_rom_cen;
    assign bus.rom_h18  = r_rom_addr[18];
    assign bus.rom_h18n = ~r_rom_addr[18];
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_id    = r_rd_id;
    assign bus.rd_vld   = r_rd_vld;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_k051962_gfx_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_k051962_gfx_rom_arbiter
// Brief    : Directed self-checking bench for the GFX ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k051962_gfx_rom_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    k051962_gfx_rom_arbiter_if bus();

    k051962_gfx_rom_arbiter #(
        .SLOT_CYC   (8),
        .SAMPLE_CYC (7),
        .CPU_STARVE (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [18:0] a);
        return {a[7:0], 5'b10110, a} ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.rom_data = rom_word(bus.rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 4'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'd0;
        bus.fix_addr = 19'd0;
        bus.a_addr = 19'd0;
        bus.b_addr = 19'd0;
        bus.cpu_addr = 19'd0;
        #2;
        total++;
        if (bus.rom_cen !== 1'b1 || bus.rom_addr !== 19'd0 || bus.gnt !== 4'd0 ||
            bus.rd_vld !== 1'b0 || bus.rom_h18n !== 1'b1 || bus.rom_h18 !== 1'b0 ||
            bus.busy !== 1'b0 || bus.rd_data !== 32'd0 || bus.rd_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: cen=%b addr=%h gnt=%b vld=%b h18n=%b busy=%b rd_data=%h required cen=1 addr=0 gnt=0 vld=0 h18n=1 busy=0 rd_data=0",
                     bus.rom_cen, bus.rom_addr, bus.gnt, bus.rd_vld, bus.rom_h18n, bus.busy, bus.rd_data);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_fix();
        bus.req = 4'b0001;
        bus.fix_addr = 19'h00003;
        tick();
        total++;
        if (bus.gnt !== 4'b0001 || bus.rom_addr !== 19'h00003 || bus.rom_cen !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant: gnt=%b addr=%h cen=%b busy=%b required 0001 00003 0 1",
                     bus.gnt, bus.rom_addr, bus.rom_cen, bus.busy);
        end
        bus.req = 4'd0;
        for (int c = 1; c < 8; c++) begin
            tick();
            total++;
            if (bus.gnt !== 4'd0 || bus.rom_addr !== 19'h00003 || bus.rom_cen !== 1'b0 || bus.rd_vld !== 1'b0) begin
                bad++;
                $display("FAIL single_hold c%0d: gnt=%b addr=%h cen=%b vld=%b required 0000 00003 0 0",
                         c, bus.gnt, bus.rom_addr, bus.rom_cen, bus.rd_vld);
            end
        end
        tick();
        total++;
        if (bus.rd_vld !== 1'b1 || bus.rd_id !== 2'd0 || bus.rd_data !== rom_word(19'h00003) ||
            bus.rom_cen !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_read: vld=%b id=%0d data=%h cen=%b busy=%b required 1 0 %h 1 0",
                     bus.rd_vld, bus.rd_id, bus.rd_data, bus.rom_cen, bus.busy, rom_word(19'h00003));
        end
        tick();
        total++;
        if (bus.rd_vld !== 1'b0) begin
            bad++;
            $display("FAIL single_vld_pulse: vld=%b required 0", bus.rd_vld);
        end
    endtask

    task automatic test_round_robin();
        int          order [6];
        logic [18:0] addr_tab [4];
        logic [3:0]  exp_gnt;
        order = '{0, 1, 2, 0, 1, 2};
        addr_tab = '{19'h00010, 19'h00020, 19'h00030, 19'h00000};
        do_reset();
        bus.fix_addr = addr_tab[0];
        bus.a_addr = addr_tab[1];
        bus.b_addr = addr_tab[2];
        bus.req = 4'b0111;
        tick();
        for (int s = 0; s < 6; s++) begin
            exp_gnt = 4'b0001 << order[s];
            total++;
            if (bus.gnt !== exp_gnt || bus.rom_addr !== addr_tab[order[s]] || bus.rom_cen !== 1'b0) begin
                bad++;
                $display("FAIL rr_grant s%0d: gnt=%b addr=%h cen=%b required %b %h 0",
                         s, bus.gnt, bus.rom_addr, bus.rom_cen, exp_gnt, addr_tab[order[s]]);
            end
            if (s > 0) begin
                total++;
                if (bus.rd_vld !== 1'b1 || bus.rd_id !== 2'(order[s-1]) ||
                    bus.rd_data !== rom_word(addr_tab[order[s-1]])) begin
                    bad++;
                    $display("FAIL rr_read s%0d: vld=%b id=%0d data=%h required 1 %0d %h",
                             s, bus.rd_vld, bus.rd_id, bus.rd_data, order[s-1], rom_word(addr_tab[order[s-1]]));
                end
            end
            for (int c = 1; c < 8; c++) begin
                tick();
                total++;
                if (bus.rom_cen !== 1'b0 || bus.gnt !== 4'd0) begin
                    bad++;
                    $display("FAIL rr_cen s%0d c%0d: cen=%b gnt=%b required 0 0000", s, c, bus.rom_cen, bus.gnt);
                end
            end
            if (s == 5) bus.req = 4'd0;
            tick();
        end
        total++;
        if (bus.rd_vld !== 1'b1 || bus.rd_id !== 2'd2 || bus.rom_cen !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_tail: vld=%b id=%0d cen=%b busy=%b required 1 2 1 0",
                     bus.rd_vld, bus.rd_id, bus.rom_cen, bus.busy);
        end
    endtask

    task automatic test_cpu_starve();
        int          order [6];
        logic [18:0] addr_tab [4];
        logic [3:0]  exp_gnt;
        order = '{0, 1, 2, 0, 3, 1};
        addr_tab = '{19'h00100, 19'h00200, 19'h00300, 19'h4001C};
        do_reset();
        bus.fix_addr = addr_tab[0];
        bus.a_addr = addr_tab[1];
        bus.b_addr = addr_tab[2];
        bus.cpu_addr = addr_tab[3];
        bus.req = 4'b1111;
        tick();
        for (int s = 0; s < 6; s++) begin
            exp_gnt = 4'b0001 << order[s];
            total++;
            if (bus.gnt !== exp_gnt || bus.rom_addr !== addr_tab[order[s]]) begin
                bad++;
                $display("FAIL starve_grant s%0d: gnt=%b addr=%h required %b %h",
                         s, bus.gnt, bus.rom_addr, exp_gnt, addr_tab[order[s]]);
            end
            total++;
            if (bus.rom_h18 !== (order[s] == 3) || bus.rom_h18n !== (order[s] != 3)) begin
                bad++;
                $display("FAIL starve_half s%0d: h18=%b h18n=%b required %b %b",
                         s, bus.rom_h18, bus.rom_h18n, (order[s] == 3), (order[s] != 3));
            end
            if (s > 0) begin
                total++;
                if (bus.rd_vld !== 1'b1 || bus.rd_id !== 2'(order[s-1]) ||
                    bus.rd_data !== rom_word(addr_tab[order[s-1]])) begin
                    bad++;
                    $display("FAIL starve_read s%0d: vld=%b id=%0d data=%h required 1 %0d %h",
                             s, bus.rd_vld, bus.rd_id, bus.rd_data, order[s-1], rom_word(addr_tab[order[s-1]]));
                end
            end
            for (int c = 1; c < 8; c++) tick();
            if (s == 5) bus.req = 4'd0;
            tick();
        end
        total++;
        if (bus.rom_cen !== 1'b1 || bus.rd_id !== 2'd1) begin
            bad++;
            $display("FAIL starve_tail: cen=%b id=%0d required 1 1", bus.rom_cen, bus.rd_id);
        end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        bus.b_addr = 19'h12345;
        bus.req = 4'b0100;
        tick();
        total++;
        if (bus.gnt !== 4'b0100 || bus.rom_addr !== 19'h12345) begin
            bad++;
            $display("FAIL midrst_grant: gnt=%b addr=%h required 0100 12345", bus.gnt, bus.rom_addr);
        end
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.rom_cen !== 1'b1 || bus.rom_addr !== 19'd0 || bus.gnt !== 4'd0 ||
            bus.rd_vld !== 1'b0 || bus.rom_h18n !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: cen=%b addr=%h gnt=%b vld=%b h18n=%b busy=%b required 1 0 0 0 1 0",
                     bus.rom_cen, bus.rom_addr, bus.gnt, bus.rd_vld, bus.rom_h18n, bus.busy);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (bus.rd_vld !== 1'b0 || bus.rom_cen !== 1'b1) begin
                bad++;
                $display("FAIL midrst_hold c%0d: vld=%b cen=%b required 0 1", c, bus.rd_vld, bus.rom_cen);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.gnt !== 4'b0100 || bus.rom_addr !== 19'h12345 || bus.rom_cen !== 1'b0) begin
            bad++;
            $display("FAIL midrst_regrant: gnt=%b addr=%h cen=%b required 0100 12345 0",
                     bus.gnt, bus.rom_addr, bus.rom_cen);
        end
        bus.req = 4'd0;
        for (int c = 1; c < 8; c++) tick();
        total++;
        if (bus.rom_cen !== 1'b0 || bus.rd_vld !== 1'b0) begin
            bad++;
            $display("FAIL midrst_slot: cen=%b vld=%b required 0 0", bus.rom_cen, bus.rd_vld);
        end
        tick();
        total++;
        if (bus.rd_vld !== 1'b1 || bus.rd_id !== 2'd2 || bus.rd_data !== rom_word(19'h12345)) begin
            bad++;
            $display("FAIL midrst_read: vld=%b id=%0d data=%h required 1 2 %h",
                     bus.rd_vld, bus.rd_id, bus.rd_data, rom_word(19'h12345));
        end
    endtask

    task automatic test_dropped_req();
        do_reset();
        bus.fix_addr = 19'h00055;
        bus.a_addr = 19'h00777;
        bus.req = 4'b0001;
        tick();
        bus.req = 4'd0;
        tick();
        tick();
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'd0;
        for (int c = 4; c < 8; c++) begin
            total++;
            if (bus.gnt !== 4'd0 || bus.rom_addr !== 19'h00055) begin
                bad++;
                $display("FAIL drop_slot c%0d: gnt=%b addr=%h required 0000 00055", c, bus.gnt, bus.rom_addr);
            end
            tick();
        end
        total++;
        if (bus.rd_vld !== 1'b1 || bus.rd_id !== 2'd0 || bus.rom_cen !== 1'b1 ||
            bus.busy !== 1'b0 || bus.gnt !== 4'd0) begin
            bad++;
            $display("FAIL drop_end: vld=%b id=%0d cen=%b busy=%b gnt=%b required 1 0 1 0 0000",
                     bus.rd_vld, bus.rd_id, bus.rom_cen, bus.busy, bus.gnt);
        end
        tick();
        total++;
        if (bus.gnt !== 4'd0 || bus.busy !== 1'b0 || bus.rom_addr !== 19'h00055) begin
            bad++;
            $display("FAIL drop_idle: gnt=%b busy=%b addr=%h required 0000 0 00055",
                     bus.gnt, bus.busy, bus.rom_addr);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single_fix();
        test_round_robin();
        test_cpu_starve();
        test_reset_mid_slot();
        test_dropped_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
